// File: rtl/imm_decode_queue.sv
// imm_decode_queue
//   Decode/issue buffer between instruction fetch and decode. Each fetched
//   instruction is classified at push time into the 3-bit immediate-format
//   select code and is queued together with its PC in a DEPTH-entry FIFO.
//
// Ports
//   CLK              clock, all state on rising edge
//   RESET            asynchronous active-low reset
//   IN_VALID/READY   fetch-side handshake (READY depends only on fill level)
//   IN_INSTRUCTION   fetched instruction word
//   IN_PC            PC of the fetched instruction
//   FLUSH            synchronous discard of all queued and incoming entries
//   OUT_VALID/READY  decode-side handshake
//   OUT_INSTRUCTION  head instruction (0 when empty)
//   OUT_PC           head PC (0 when empty)
//   IMM_SELECT       head immediate-format select (0 when empty)
//   IMM_ILLEGAL      head opcode unrecognised (0 when empty)
//   ILLEGAL_COUNT    saturating count of illegal opcodes accepted since reset
module imm_decode_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IN_INSTRUCTION,
  input  logic [31:0]      IN_PC,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_INSTRUCTION,
  output logic [31:0]      OUT_PC,
  output logic [2:0]       IMM_SELECT,
  output logic             IMM_ILLEGAL,
  output logic [CNT_W-1:0] ILLEGAL_COUNT
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    FMT_U   = 3'b000,
    FMT_J   = 3'b001,
    FMT_I   = 3'b010,
    FMT_B   = 3'b011,
    FMT_S   = 3'b100,
    FMT_R   = 3'b101,
    FMT_BAD = 3'b111
  } imm_fmt_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_BRANCH = 7'b1100011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  logic [CW-1:0]    count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic [31:0] ins_mem [DEPTH];
  logic [31:0] pc_mem  [DEPTH];
  logic [2:0]  sel_mem [DEPTH];
  logic        ill_mem [DEPTH];

  imm_fmt_e dec_sel;
  logic     dec_ill;
  logic     push;
  logic     pop;

  // Opcode classification, done once at push and stored with the entry.
  always_comb begin
    dec_sel = FMT_BAD;
    dec_ill = 1'b0;
    case (IN_INSTRUCTION[6:0])
      OPC_LUI, OPC_AUIPC:            dec_sel = FMT_U;
      OPC_JAL:                       dec_sel = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: dec_sel = FMT_I;
      OPC_BRANCH:                    dec_sel = FMT_B;
      OPC_STORE:                     dec_sel = FMT_S;
      OPC_OP:                        dec_sel = FMT_R;
      default: begin
        dec_sel = FMT_BAD;
        dec_ill = 1'b1;
      end
    endcase
  end

  // Ready looks only at the registered fill level, so a full queue refuses
  // a push even when decode drains the head in the same cycle.
  assign IN_READY  = (count_q < FULL_CNT);
  assign OUT_VALID = (count_q != '0);
  assign push      = IN_VALID & IN_READY & ~FLUSH;
  assign pop       = OUT_VALID & OUT_READY & ~FLUSH;

  always_comb begin
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    ill_cnt_d = ill_cnt_q;
    if (FLUSH) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (dec_ill && (ill_cnt_q != '1)) begin
          ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      ill_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Entry storage needs no reset: it is only observable while count_q != 0.
  always_ff @(posedge CLK) begin
    if (push) begin
      ins_mem[wr_ptr_q] <= IN_INSTRUCTION;
      pc_mem[wr_ptr_q]  <= IN_PC;
      sel_mem[wr_ptr_q] <= dec_sel;
      ill_mem[wr_ptr_q] <= dec_ill;
    end
  end

  always_comb begin
    OUT_INSTRUCTION = '0;
    OUT_PC          = '0;
    IMM_SELECT      = '0;
    IMM_ILLEGAL     = 1'b0;
    if (OUT_VALID) begin
      OUT_INSTRUCTION = ins_mem[rd_ptr_q];
      OUT_PC          = pc_mem[rd_ptr_q];
      IMM_SELECT      = sel_mem[rd_ptr_q];
      IMM_ILLEGAL     = ill_mem[rd_ptr_q];
    end
  end

  assign ILLEGAL_COUNT = ill_cnt_q;

endmodule

// File: tb/tb_imm_decode_queue.sv
// Self-checking bench for imm_decode_queue: directed steps plus random
// traffic, compared against a queue-based reference model.
module tb_imm_decode_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             IN_VALID;
  logic             IN_READY;
  logic [31:0]      IN_INSTRUCTION;
  logic [31:0]      IN_PC;
  logic             FLUSH;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [31:0]      OUT_INSTRUCTION;
  logic [31:0]      OUT_PC;
  logic [2:0]       IMM_SELECT;
  logic             IMM_ILLEGAL;
  logic [CNT_W-1:0] ILLEGAL_COUNT;

  imm_decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .IN_VALID        (IN_VALID),
    .IN_READY        (IN_READY),
    .IN_INSTRUCTION  (IN_INSTRUCTION),
    .IN_PC           (IN_PC),
    .FLUSH           (FLUSH),
    .OUT_VALID       (OUT_VALID),
    .OUT_READY       (OUT_READY),
    .OUT_INSTRUCTION (OUT_INSTRUCTION),
    .OUT_PC          (OUT_PC),
    .IMM_SELECT      (IMM_SELECT),
    .IMM_ILLEGAL     (IMM_ILLEGAL),
    .ILLEGAL_COUNT   (ILLEGAL_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   ref_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  logic [6:0] legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111,
                                7'b1100111, 7'b0000011, 7'b0010011,
                                7'b1100011, 7'b0100011, 7'b0110011};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Format table written from the opcode list.
  function automatic logic [3:0] ref_fmt(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'b0110111 || op == 7'b0010111) return 4'b0000;
    if (op == 7'b1101111) return 4'b0001;
    if (op == 7'b1100111 || op == 7'b0000011 || op == 7'b0010011) return 4'b0010;
    if (op == 7'b1100011) return 4'b0011;
    if (op == 7'b0100011) return 4'b0100;
    if (op == 7'b0110011) return 4'b0101;
    return 4'b1111;  // {illegal, select=111}
  endfunction

  // Compare all outputs to the model.
  task automatic check_outputs();
    logic [3:0] f;
    chk("in_ready", 32'(IN_READY), 32'(mq.size() < DEPTH));
    chk("ill_count", 32'(ILLEGAL_COUNT), 32'(ref_cnt));
    if (mq.size() == 0) begin
      chk("out_valid", 32'(OUT_VALID), 32'd0);
      chk("out_ins_zero", OUT_INSTRUCTION, 32'd0);
      chk("out_pc_zero", OUT_PC, 32'd0);
      chk("sel_zero", 32'(IMM_SELECT), 32'd0);
      chk("ill_zero", 32'(IMM_ILLEGAL), 32'd0);
    end else begin
      f = ref_fmt(mq[0].ins);
      chk("out_valid", 32'(OUT_VALID), 32'd1);
      chk("out_ins", OUT_INSTRUCTION, mq[0].ins);
      chk("out_pc", OUT_PC, mq[0].pc);
      chk("imm_select", 32'(IMM_SELECT), 32'(f[2:0]));
      chk("imm_illegal", 32'(IMM_ILLEGAL), 32'(f[3]));
    end
  endtask

  // One clock cycle: drive, check, advance model at posedge, return at negedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    logic push, pop;
    logic [3:0] f;
    IN_VALID = v; IN_INSTRUCTION = ins; IN_PC = pc; FLUSH = fl; OUT_READY = ordy;
    #1;
    check_outputs();
    push = v && (mq.size() < DEPTH) && !fl;
    pop  = (mq.size() != 0) && ordy && !fl;
    @(posedge CLK);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{ins: ins, pc: pc});
        f = ref_fmt(ins);
        if (f[3] && ref_cnt < CNT_MAX) ref_cnt++;
      end
    end
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [31:0] s;
    r = $urandom();
    s = $urandom_range(0, 11);
    if (s < 9) return {r[31:7], legal_ops[s]};
    return r;
  endfunction

  initial begin
    RESET = 1'b0; IN_VALID = 1'b0; IN_INSTRUCTION = '0; IN_PC = '0;
    FLUSH = 1'b0; OUT_READY = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check_outputs();
    RESET = 1'b1;
    @(negedge CLK);

    // Idle after reset
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Single LUI through an empty queue
    cycle(1'b1, 32'h123450B7, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Fill with decode stalled; third word is refused while full
    cycle(1'b1, 32'h0080006F, 32'h4, 1'b0, 1'b0);
    cycle(1'b1, 32'h00208463, 32'h8, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000013, 32'hC, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000013, 32'hC, 1'b0, 1'b0);
    chk("full_not_ready", 32'(IN_READY), 32'd0);
    cycle(1'b1, 32'h00000013, 32'hC, 1'b0, 1'b1);
    cycle(1'b1, 32'h00000013, 32'hC, 1'b0, 1'b1);
    cycle(1'b1, 32'h00000013, 32'hC, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Back-to-back stream
    cycle(1'b1, 32'h00500093, 32'h10, 1'b0, 1'b1);
    cycle(1'b1, 32'h00112023, 32'h14, 1'b0, 1'b1);
    cycle(1'b1, 32'h002081B3, 32'h18, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush with a full queue and an incoming word
    cycle(1'b1, 32'h00000037, 32'h20, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000017, 32'h24, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000006F, 32'h28, 1'b1, 1'b1);
    chk("flush_empty", 32'(OUT_VALID), 32'd0);
    chk("flush_ready", 32'(IN_READY), 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush while a single entry and an illegal word arrive
    cycle(1'b1, 32'h00000033, 32'h30, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000007F, 32'h34, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_ins(), $urandom(),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
    end

    // Reset, then an illegal stream long enough to saturate the counter
    RESET = 1'b0;
    mq.delete();
    ref_cnt = 0;
    #1;
    check_outputs();
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 260; i++) begin
      cycle(1'b1, {$urandom_range(0, 33554431), 7'b0000000}, 32'(i * 4), 1'b0, 1'b1);
    end
    chk("ill_saturated", 32'(ILLEGAL_COUNT), 32'(CNT_MAX));
    cycle(1'b1, 32'h00000000, 32'h1000, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000001, 32'h1004, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(OUT_VALID), 32'd1);

    // Asynchronous reset mid-cycle, away from any clock edge
    #2;
    RESET = 1'b0;
    #1;
    mq.delete();
    ref_cnt = 0;
    chk("async_valid", 32'(OUT_VALID), 32'd0);
    chk("async_ins", OUT_INSTRUCTION, 32'd0);
    chk("async_pc", OUT_PC, 32'd0);
    chk("async_sel", 32'(IMM_SELECT), 32'd0);
    chk("async_ill", 32'(IMM_ILLEGAL), 32'd0);
    chk("async_cnt", 32'(ILLEGAL_COUNT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    cycle(1'b1, 32'h00000063, 32'h2000, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
